beam_draw_arbiter: RTL and testbench
====================================

# beam_draw_arbiter

Shares the single 2x4 beam-block pixel drawer between N requesters, e.g. several player beams and the erase pass, on the VGA path. Picks one pending request and presents that requester's x/y/colour to the drawer. Pulses the drawer's go, waits for its done, then acknowledges the requester. It sits between the game-logic FSMs and the drawer; the drawer's writeEn/x/y/c continue to the VGA adapter untouched.

## Interface
- N_REQ, 4: number of requesters (2..8).
- TIMEOUT, 255: max cycles to wait for drawer done before aborting (8-bit counter).

- CLOCK_50  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req  in  N_REQ  level request per requester; held high until matching ack.
- req_x  in  8*N_REQ  packed x per requester, requester i at [8i+7:8i].
- req_y  in  7*N_REQ  packed y, requester i at [7i+6:7i].
- req_colour  in  3*N_REQ  packed colour, requester i at [3i+2:3i].
- ack  out  N_REQ  one-hot, one-cycle pulse: the block for requester i has been drawn.
- bc_go  out  1  one-cycle start pulse to drawer.
- bc_x  out  8  x to drawer.
- bc_y  out  7  y to drawer.
- bc_colour  out  3  colour to drawer.
- bc_done  in  1  drawer completion pulse.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on abort, cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If req is nonzero, select the winner.
  - Latch the winner's req_x/req_y/req_colour into bc_x/bc_y/bc_colour.
  - Store the winner index, then go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE: bc_go=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT:
  - bc_done=1 goes to ACK.
  - If the counter reaches TIMEOUT, set timeout_err and go to ACK.
  - Otherwise increment the counter.
- ACK:
  - ack[winner]=1 for this cycle.
  - Round-robin pointer becomes winner+1, wrapping from N_REQ-1 to 0.
  - Go to IDLE.
- bc_x/bc_y/bc_colour update only on the IDLE to ISSUE transition. They are held stable through ISSUE, WAIT and ACK, because the drawer loads coordinates one cycle after go.
- Requester inputs are sampled only in IDLE. Changing them or dropping req during service does not affect the block in flight; it still completes and is still acked.
- bc_done outside WAIT is ignored.
- A timed-out request is still acked, so the requester is not hung. Software checks timeout_err.

## Timing
- Reset values:
  - state IDLE, RR pointer 0, counter 0.
  - ack=0, bc_go=0, busy=0, timeout_err=0.
  - bc_x=0, bc_y=0, bc_colour=0.
- Latency: req seen in IDLE at cycle t gives bc_go at t+1. bc_done at cycle d gives ack at d+1 and IDLE at d+2.
- Minimum spacing between consecutive bc_go pulses is 4 cycles (ISSUE, WAIT≥1, ACK, IDLE). This guarantees the drawer has returned to its load state.
- A requester whose req is still high in the cycle after its ack is treated as a new request.
- Reset mid-operation: immediate return to reset values next edge; no ack is issued for the aborted block.

## Configuration
- DRAW_ARB_RR_EN defined: round-robin. Search starts at the RR pointer and the first asserted req wins, so every requester with req held is served within N_REQ grants.
- Undefined: fixed priority, lowest asserted index wins; the RR pointer is not implemented.

## Test plan
- Single request: req=0001, req_x[7:0]=8'd10, y=7'd20, colour=3'b100.
  - Expect bc_go one cycle later with bc_x=10, bc_y=20, bc_colour=100.
  - Drawer model returns done 10 cycles later; ack=0001 the next cycle, busy low after.
- All requesters held (req=1111) with DRAW_ARB_RR_EN, 0-cycle-gap model:
  - Acks in order 0001,0010,0100,1000,0001.
  - Without the macro: every ack is 0001.
- Input change mid-service: after bc_go, change req_x[7:0] to 8'd99 and drop req[0].
  - bc_x stays 10 until ack.
  - ack[0] still pulses.
- Timeout: drawer never asserts done.
  - Exactly TIMEOUT+1 cycles after bc_go, ack pulses and timeout_err=1.
  - timeout_err stays 1 through the next request until reset.
- Spurious/late done: bc_done pulsed in IDLE gives no ack.
  - Reset asserted in WAIT: next cycle state IDLE, all outputs 0, no ack.

Source files
------------

// File: rtl/beam_draw_arbiter_if.sv
// Requester and drawer bus for beam_draw_arbiter.
// master: the arbiter (drives acks and the drawer command).
// slave: the environment (requesters and the drawer).
interface beam_draw_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_x;
  logic [7*N_REQ-1:0] req_y;
  logic [3*N_REQ-1:0] req_colour;
  logic [N_REQ-1:0]   ack;
  logic               bc_go;
  logic [7:0]         bc_x;
  logic [6:0]         bc_y;
  logic [2:0]         bc_colour;
  logic               bc_done;

  modport master (
    input  req, req_x, req_y, req_colour, bc_done,
    output ack, bc_go, bc_x, bc_y, bc_colour
  );

  modport slave (
    output req, req_x, req_y, req_colour, bc_done,
    input  ack, bc_go, bc_x, bc_y, bc_colour
  );
endinterface

// File: rtl/beam_draw_arbiter.sv
// Shares the 2x4 beam-block drawer between N_REQ requesters.
// The winning requester's x/y/colour are latched and sent to the drawer.
// bc_go is pulsed, the arbiter waits for bc_done (bounded by TIMEOUT) and
// then acknowledges the requester.
// Optional feature: define DRAW_ARB_RR_EN for round-robin arbitration;
// otherwise the lowest asserted index wins.
module beam_draw_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  beam_draw_arbiter_if.master bus,
  output logic                busy,
  output logic                timeout_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 8;
  // Compare against TIMEOUT-1 so the abort lands TIMEOUT+1 cycles after go.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   winner, winner_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [IDX_W-1:0]   pick_c;
  logic               pick_valid_c;
  logic [7:0]         sel_x_c, x_d;
  logic [6:0]         sel_y_c, y_d;
  logic [2:0]         sel_colour_c, colour_d;
  logic [N_REQ-1:0]   ack_d;
  logic               go_d;
  logic               busy_d;
  logic               err_d;

`ifdef DRAW_ARB_RR_EN
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;

  // Requester index at offset off from base, wrapping at N_REQ.
  function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction
`endif

  // Winner selection among asserted requests.
  always_comb begin
    pick_valid_c = 1'b0;
    pick_c       = '0;
`ifdef DRAW_ARB_RR_EN
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!pick_valid_c && bus.req[rr_slot(rr_ptr, k)]) begin
        pick_valid_c = 1'b1;
        pick_c       = rr_slot(rr_ptr, k);
      end
    end
`else
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!pick_valid_c && bus.req[i]) begin
        pick_valid_c = 1'b1;
        pick_c       = IDX_W'(i);
      end
    end
`endif
  end

  // Coordinate mux for the selected requester.
  always_comb begin
    sel_x_c      = '0;
    sel_y_c      = '0;
    sel_colour_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_c == IDX_W'(i)) begin
        sel_x_c      = bus.req_x[8*i +: 8];
        sel_y_c      = bus.req_y[7*i +: 7];
        sel_colour_c = bus.req_colour[3*i +: 3];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    winner_d = winner;
    cnt_d    = cnt;
    x_d      = bus.bc_x;
    y_d      = bus.bc_y;
    colour_d = bus.bc_colour;
    err_d    = timeout_err;
`ifdef DRAW_ARB_RR_EN
    rr_ptr_d = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (pick_valid_c) begin
          state_d  = ISSUE;
          winner_d = pick_c;
          x_d      = sel_x_c;
          y_d      = sel_y_c;
          colour_d = sel_colour_c;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.bc_done) begin
          state_d = ACK;
        end else if (cnt == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ACK: begin
`ifdef DRAW_ARB_RR_EN
        rr_ptr_d = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    go_d   = (state_d == ISSUE);
    busy_d = (state_d != IDLE);
    ack_d  = (state_d == ACK) ? (N_REQ'(1) << winner_d) : '0;
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      winner        <= '0;
      cnt           <= '0;
      bus.ack       <= '0;
      bus.bc_go     <= 1'b0;
      bus.bc_x      <= '0;
      bus.bc_y      <= '0;
      bus.bc_colour <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
`ifdef DRAW_ARB_RR_EN
      rr_ptr        <= '0;
`endif
    end else begin
      state         <= state_d;
      winner        <= winner_d;
      cnt           <= cnt_d;
      bus.ack       <= ack_d;
      bus.bc_go     <= go_d;
      bus.bc_x      <= x_d;
      bus.bc_y      <= y_d;
      bus.bc_colour <= colour_d;
      busy          <= busy_d;
      timeout_err   <= err_d;
`ifdef DRAW_ARB_RR_EN
      rr_ptr        <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_beam_draw_arbiter.sv
// Self-checking bench for beam_draw_arbiter (directed scenarios + random traffic).
// The reference model tracks each grant as a transaction with absolute cycle
// times for go, ack and the return to idle. Honours DRAW_ARB_RR_EN.
module tb_beam_draw_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned TIMEOUT = 255;
  localparam int          INF     = 32'h7fffffff;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic timeout_err;

  beam_draw_arbiter_if #(.N_REQ(N)) bus_if ();

  beam_draw_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .bus         (bus_if),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Stimulus state
  logic [N-1:0] req_v = '0;
  logic [7:0]   rx [N];
  logic [6:0]   ry [N];
  logic [2:0]   rc [N];
  logic [N-1:0] pend = '0;
  logic [N-1:0] drop = '0;
  int           next_delay = 1;
  bit           spur = 0;
  bit           rst_pulse = 0;
  bit           mode_rand = 0;

  // Reference model state (absolute cycle times of the current transaction)
  int           go_due = -1;
  int           ack_due = -1;
  int           done_at = -1;
  int           idle_from = 0;
  int           err_from = INF;
  int           ptr = 0;
  int           inflight = -1;
  logic [N-1:0] cur_onehot = '0;
  logic [7:0]   exp_x = '0;
  logic [6:0]   exp_y = '0;
  logic [2:0]   exp_c = '0;

  // Observation log
  int           last_go = -1;
  int           last_ack = -1;
  logic [N-1:0] ack_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef DRAW_ARB_RR_EN
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`else
    for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
    return -1;
  endfunction

  // Compare every output against the model for the current cycle.
  task automatic check_outputs();
    logic [N-1:0] ea;
    logic eb;
    ea = (cyc == ack_due) ? cur_onehot : '0;
    eb = (go_due >= 0) && (cyc >= go_due) && (cyc <= ack_due);
    check("ack", 32'(bus_if.ack), 32'(ea));
    check("bc_go", 32'(bus_if.bc_go), 32'(cyc == go_due));
    check("busy", 32'(busy), 32'(eb));
    check("bc_x", 32'(bus_if.bc_x), 32'(exp_x));
    check("bc_y", 32'(bus_if.bc_y), 32'(exp_y));
    check("bc_colour", 32'(bus_if.bc_colour), 32'(exp_c));
    check("timeout_err", 32'(timeout_err), 32'(cyc >= err_from));
    if (bus_if.bc_go) last_go = cyc;
    if (bus_if.ack != '0) begin
      ack_log.push_back(bus_if.ack);
      last_ack = cyc;
    end
  endtask

  // Random requester/drawer behaviour for the current cycle.
  task automatic rand_stim();
    if (inflight >= 0 && cyc == ack_due) begin
      pend[inflight] = 1'b0;
      drop[inflight] = 1'b0;
      inflight = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(3) == 0) begin
        pend[i] = 1'b1;
        rx[i] = 8'($urandom);
        ry[i] = 7'($urandom);
        rc[i] = 3'($urandom);
      end else if (pend[i] && i != inflight && $urandom_range(7) == 0) begin
        rx[i] = 8'($urandom);
      end
    end
    if (inflight >= 0 && cyc > go_due && $urandom_range(3) == 0) begin
      rx[inflight] = 8'($urandom);
      ry[inflight] = 7'($urandom);
      rc[inflight] = 3'($urandom);
      if ($urandom_range(1) == 0) drop[inflight] = 1'b1;
    end
    req_v = pend & ~drop;
    next_delay = ($urandom_range(39) == 0) ? -1 : int'($urandom_range(12, 1));
    spur = ($urandom_range(4) == 0);
  endtask

  // Drive inputs for the current cycle, advance the model, then check the next cycle.
  task automatic tick();
    int w;
    if (mode_rand) rand_stim();
    reset = rst_pulse;
    for (int i = 0; i < N; i++) begin
      bus_if.req_x[8*i +: 8]      = rx[i];
      bus_if.req_y[7*i +: 7]      = ry[i];
      bus_if.req_colour[3*i +: 3] = rc[i];
    end
    bus_if.req = req_v;
    bus_if.bc_done = (cyc == done_at) || (spur && !(cyc > go_due && cyc < ack_due));
    if (rst_pulse) begin
      go_due = -1; ack_due = -1; done_at = -1; idle_from = cyc + 1;
      err_from = INF; ptr = 0; inflight = -1; cur_onehot = '0;
      exp_x = '0; exp_y = '0; exp_c = '0;
    end else if (cyc >= idle_from && req_v != '0) begin
      w = pick(req_v, ptr);
      cur_onehot = '0;
      cur_onehot[w] = 1'b1;
      exp_x = rx[w]; exp_y = ry[w]; exp_c = rc[w];
      go_due = cyc + 1;
      if (next_delay < 0 || next_delay > int'(TIMEOUT)) begin
        done_at = -1;
        ack_due = go_due + int'(TIMEOUT) + 1;
        if (err_from == INF) err_from = ack_due;
      end else begin
        done_at = go_due + next_delay;
        ack_due = done_at + 1;
      end
      idle_from = ack_due + 1;
      ptr = (w + 1) % N;
      inflight = w;
    end
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic run_to_ack();
    for (int g = 0; g < 2000 && cyc < ack_due; g++) tick();
  endtask

  task automatic drain();
    req_v = '0;
    for (int g = 0; g < 2000 && cyc <= idle_from; g++) tick();
  endtask

  initial begin
    logic [N-1:0] exp_seq [5];
    for (int i = 0; i < N; i++) begin rx[i] = '0; ry[i] = '0; rc[i] = '0; end
    reset = 1'b1;
    bus_if.req = '0; bus_if.req_x = '0; bus_if.req_y = '0; bus_if.req_colour = '0;
    bus_if.bc_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc = 0;
    check_outputs();

    // Single request, drawer done 10 cycles after go
    req_v = N'(1); rx[0] = 8'd10; ry[0] = 7'd20; rc[0] = 3'b100; next_delay = 10;
    tick();
    check("t1_go", 32'(bus_if.bc_go), 32'd1);
    check("t1_x", 32'(bus_if.bc_x), 32'd10);
    run_to_ack();
    req_v = '0;
    check("t1_ack", 32'(bus_if.ack), 32'd1);
    check("t1_ack_gap", 32'(last_ack - last_go), 32'd11);
    tick(); tick();
    check("t1_busy_low", 32'(busy), 32'd0);

    // All requesters held, zero-gap drawer, from a fresh reset
    rst_pulse = 1; tick(); rst_pulse = 0;
    ack_log.delete();
    req_v = '1; next_delay = 1;
    for (int g = 0; g < 200 && ack_log.size() < 5; g++) tick();
    req_v = '0;
    drain();
`ifdef DRAW_ARB_RR_EN
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int k = 0; k < 5; k++)
      check($sformatf("t2_ack_order%0d", k),
            32'((k < ack_log.size()) ? ack_log[k] : '0), 32'(exp_seq[k]));

    // Requester inputs change after go; block in flight is unaffected
    req_v = N'(1); rx[0] = 8'd10; ry[0] = 7'd20; rc[0] = 3'b100; next_delay = 8;
    tick();
    rx[0] = 8'd99; req_v = '0;
    run_to_ack();
    check("t3_x_hold", 32'(bus_if.bc_x), 32'd10);
    check("t3_ack", 32'(bus_if.ack), 32'd1);
    drain();

    // Drawer never completes: abort after TIMEOUT+1 cycles, sticky error
    req_v = N'(2); rx[1] = 8'd55; ry[1] = 7'd3; rc[1] = 3'b011; next_delay = -1;
    tick();
    run_to_ack();
    req_v = '0;
    check("t4_ack", 32'(bus_if.ack), 32'd2);
    check("t4_ack_gap", 32'(last_ack - last_go), 32'(TIMEOUT + 1));
    check("t4_err", 32'(timeout_err), 32'd1);
    drain();
    req_v = N'(4); rx[2] = 8'd200; ry[2] = 7'd100; rc[2] = 3'b111; next_delay = 3;
    tick();
    run_to_ack();
    req_v = '0;
    drain();
    check("t4_err_sticky", 32'(timeout_err), 32'd1);

    // Spurious done while idle produces no ack
    ack_log.delete();
    spur = 1;
    repeat (6) tick();
    spur = 0;
    check("t5_no_ack", 32'(ack_log.size()), 32'd0);

    // Reset while waiting for the drawer
    req_v = N'(8); rx[3] = 8'd77; ry[3] = 7'd66; rc[3] = 3'b101; next_delay = 20;
    repeat (4) tick();
    check("t6_busy_before", 32'(busy), 32'd1);
    ack_log.delete();
    rst_pulse = 1; req_v = '0;
    tick();
    rst_pulse = 0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_go", 32'(bus_if.bc_go), 32'd0);
    check("t6_x", 32'(bus_if.bc_x), 32'd0);
    check("t6_err", 32'(timeout_err), 32'd0);
    repeat (25) tick();
    check("t6_no_ack", 32'(ack_log.size()), 32'd0);

    // Random traffic against the model
    pend = '0; drop = '0; inflight = -1;
    mode_rand = 1;
    repeat (3000) tick();
    mode_rand = 0;
    spur = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
